// File: rtl/mont_final_sub.sv
//------------------------------------------------------------------------------
// mont_final_sub : conditional final subtraction T mod M after Montgomery add
// Optional: FINSUB_EARLY_EXIT_EN enables a 1-edge bypass when T < M certainly.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mont_final_sub #(
  parameter int N     = 1024,
  parameter int CHUNK = 128
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [N+2:0]   in_t,
  input  logic [N-1:0]   in_m,
  output logic [N-1:0]   result,
  output logic           done,
  output logic           busy
);

  localparam int W   = N + 3;
  localparam int NCH = W / CHUNK;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    SEL  = 2'd2
  } state_t;

  state_t state;

  logic [W-1:0]       t_r;
  logic [N-1:0]       m_r;
  logic [W-1:0]       m_inv;

  logic [W-1:0]       sum1_w;
  logic [W-1:0]       sum1_r;
  logic [W-1:CHUNK]   sum0_w;
  logic [W-1:CHUNK]   sum0_r;
  logic [NCH-1:0]     c1_w;
  logic [NCH-1:0]     c1_r;
  logic [NCH-1:1]     c0_w;
  logic [NCH-1:1]     c0_r;

  logic [NCH:1]       rc;
  logic [W-1:0]       d;
  logic               cout;

  assign m_inv = ~{3'b000, m_r};
  assign busy  = (state != IDLE);

  // Chunk 0 always sees the +1 carry-in, so only its carry-in-1 variant exists.
  for (genvar k = 0; k < NCH; k++) begin : g_chunk
    localparam int LO  = k * CHUNK;
    localparam int WID = (k == NCH - 1) ? (W - LO) : CHUNK;

    logic [WID:0] s1;
    assign s1 = {1'b0, t_r[LO +: WID]} + {1'b0, m_inv[LO +: WID]} + {{WID{1'b0}}, 1'b1};
    assign sum1_w[LO +: WID] = s1[WID-1:0];
    assign c1_w[k]           = s1[WID];

    if (k == 0) begin : g_first
      assign d[LO +: WID] = sum1_r[LO +: WID];
    end else begin : g_rest
      logic [WID:0] s0;
      assign s0 = {1'b0, t_r[LO +: WID]} + {1'b0, m_inv[LO +: WID]};
      assign sum0_w[LO +: WID] = s0[WID-1:0];
      assign c0_w[k]           = s0[WID];
      assign d[LO +: WID]      = rc[k] ? sum1_r[LO +: WID] : sum0_r[LO +: WID];
    end
  end

  always_comb begin
    rc    = '0;
    rc[1] = c1_r[0];
    for (int k = 1; k < NCH; k++) begin
      rc[k+1] = rc[k] ? c1_r[k] : c0_r[k];
    end
  end

  assign cout = rc[NCH];

  // Bits above N only feed the carry; the difference itself is N bits wide.
  logic unused_hi;
  assign unused_hi = ^d[W-1:N];

`ifdef FINSUB_EARLY_EXIT_EN
  logic early;
  assign early = (in_t[N+2:N] == 3'b000) && (in_t[N-1:N-16] < in_m[N-1:N-16]);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      result <= '0;
      done   <= 1'b0;
      t_r    <= '0;
      m_r    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
`ifdef FINSUB_EARLY_EXIT_EN
            if (early) begin
              result <= in_t[N-1:0];
              done   <= 1'b1;
            end else begin
              t_r   <= in_t;
              m_r   <= in_m;
              state <= ADD;
            end
`else
            t_r   <= in_t;
            m_r   <= in_m;
            state <= ADD;
`endif
          end
        end
        ADD: state <= SEL;
        SEL: begin
          result <= cout ? d[N-1:0] : t_r[N-1:0];
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sum1_r <= '0;
      sum0_r <= '0;
      c1_r   <= '0;
      c0_r   <= '0;
    end else if (state == ADD) begin
      sum1_r <= sum1_w;
      sum0_r <= sum0_w;
      c1_r   <= c1_w;
      c0_r   <= c0_w;
    end
  end

endmodule

`default_nettype wire
